// File: rtl/background_sequencer_if.sv
// Host configuration write port of the background sequencer.
// The host drives valid/addr/data; the sequencer answers with ready.
interface background_sequencer_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/background_sequencer.sv
// Frame-synchronous playlist and time-base sequencer for the background generator.
// Host writes land in staging and reach the active copy only at a frame-boundary commit.
module background_sequencer #(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    background_sequencer_if.slave cfg,
    input  logic                  frame_start,
    input  logic                  enable,
    output logic [1:0]            bg_select,
    output logic [7:0]            cur_time,
    output logic [1:0]            slot,
    output logic                  update
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        APPLY
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] stg_slot_q [NUM_SLOTS];
    logic [7:0] stg_ctrl_q;
    logic [7:0] act_slot_q [NUM_SLOTS];
    logic [7:0] act_ctrl_q;
    logic       dirty_q, dirty_d;
    logic [1:0] slot_q, slot_d;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic [7:0] time_q, time_d;

    logic       ready;
    logic       wr_fire, wr_slot, wr_ctrl, wr_hit;
    logic       commit, step;
    logic [5:0] cur_dur;
    logic       act_loop, act_freeze;
    logic [1:0] act_len;
    logic [3:0] act_speed;

    assign ready      = (state_q != APPLY);
    assign cur_dur    = act_slot_q[slot_q][7:2];
    assign act_loop   = act_ctrl_q[7];
    assign act_freeze = act_ctrl_q[6];
    assign act_len    = act_ctrl_q[5:4];
    assign act_speed  = act_ctrl_q[3:0];

    always_comb begin
        wr_fire = cfg.cfg_valid && ready;
        wr_slot = wr_fire && !cfg.cfg_addr[2];
        wr_ctrl = wr_fire && (cfg.cfg_addr == 3'd4);
        wr_hit  = wr_slot || wr_ctrl;
        commit  = frame_start && dirty_q && (state_q != APPLY);
        step    = frame_start && !dirty_q && (state_q == PLAY) && enable;

        state_d     = enable ? PLAY : IDLE;
        dirty_d     = dirty_q || wr_hit;
        slot_d      = slot_q;
        frame_cnt_d = frame_cnt_q;
        div_cnt_d   = div_cnt_q;
        time_d      = time_q;

        if (commit) begin
            // A write accepted alongside the commit misses this copy, so it stays pending.
            state_d     = APPLY;
            dirty_d     = wr_hit;
            slot_d      = '0;
            frame_cnt_d = '0;
            div_cnt_d   = '0;
        end else if (step) begin
            if (frame_cnt_q != cur_dur) begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end else if (slot_q != act_len) begin
                slot_d      = slot_q + 2'd1;
                frame_cnt_d = '0;
            end else if (act_loop) begin
                slot_d      = '0;
                frame_cnt_d = '0;
            end
            // Without loop_en the last slot is held with frame_cnt parked at dur.

            if (!act_freeze) begin
                if (div_cnt_q == act_speed) begin
                    div_cnt_d = '0;
                    time_d    = time_q + 8'd1;
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dirty_q     <= 1'b0;
            slot_q      <= '0;
            frame_cnt_q <= '0;
            div_cnt_q   <= '0;
            time_q      <= '0;
            stg_ctrl_q  <= '0;
            act_ctrl_q  <= '0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                stg_slot_q[i] <= '0;
                act_slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            dirty_q     <= dirty_d;
            slot_q      <= slot_d;
            frame_cnt_q <= frame_cnt_d;
            div_cnt_q   <= div_cnt_d;
            time_q      <= time_d;

            if (wr_slot) begin
                stg_slot_q[cfg.cfg_addr[1:0]] <= cfg.cfg_data;
            end
            if (wr_ctrl) begin
                stg_ctrl_q <= cfg.cfg_data;
            end
            if (commit) begin
                act_ctrl_q <= stg_ctrl_q;
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    act_slot_q[i] <= stg_slot_q[i];
                end
            end
        end
    end

    assign cfg.cfg_ready = ready;
    assign update        = (state_q == APPLY);
    assign bg_select     = act_slot_q[slot_q][1:0];
    assign cur_time      = time_q;
    assign slot          = slot_q;

endmodule

// File: doc/background_sequencer.md
# background_sequencer

Frame-synchronous controller for the background generator. It owns the `bg_select` and `cur_time` inputs of the background datapath: it steps through a programmable playlist of up to four background modes with per-slot durations, and it advances the animation time base at a programmable rate. Host configuration arrives over a valid/ready write port into staging registers. Staged values commit atomically at a frame boundary, so a frame never shows a half-applied configuration.

## Interface
Parameters:
- `NUM_SLOTS`, default 4: playlist depth. Fixed at 4; the slot index is 2 bits.

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  synchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse at the start of vertical blanking
- `enable`  in  1  1 = playlist and time advance on each frame; 0 = hold
- `cfg_valid`  in  1  configuration write request
- `cfg_ready`  out  1  write accepted when `cfg_valid && cfg_ready`
- `cfg_addr`  in  3  staging register address
- `cfg_data`  in  8  write data
- `bg_select`  out  2  background mode sent to the background generator
- `cur_time`  out  8  animation time sent to the background generator
- `slot`  out  2  current playlist slot
- `update`  out  1  one-cycle pulse in the cycle a commit takes effect

## Operation
- **Staging registers**
  - Addr 0–3 are slot entries `{dur[5:0], bg[1:0]}`. A slot lasts `dur+1` frames.
  - Addr 4 is control `{loop_en[7], freeze[6], len[5:4], speed[3:0]}`.
  - Addr 5–7 accept writes and have no effect; those writes do not set `dirty`.
  - Every accepted write to addr 0–4 sets `dirty`.
- **Active registers** are a copy of staging, loaded only on commit. Only the active copy drives behaviour.
- **bg_select** = `active_bg[slot]`, combinational from registers.
- **FSM states: IDLE, PLAY, APPLY.**
  - IDLE is the state after reset and whenever `enable=0`.
  - On any `frame_start` with `dirty=1` (from IDLE or PLAY), the next state is APPLY.
  - In APPLY:
    - active ← staging, using staging contents from before any write in that same cycle.
    - `dirty` ← 0, unless a write is accepted in that `frame_start` cycle; then `dirty` stays 1.
    - `slot`, frame counter and divider counter ← 0.
    - `cur_time` holds.
  - APPLY lasts exactly 1 cycle. It then goes to PLAY if `enable=1`, else IDLE.
  - `frame_start` with `dirty=0`: in PLAY, do one advance step; in IDLE, do nothing.
  - PLAY → IDLE when `enable=0`, checked each cycle. IDLE → PLAY when `enable=1`.
- **Advance step (PLAY, on frame_start)**
  - Slot: if `frame_cnt == dur[slot]`:
    - `frame_cnt` ← 0.
    - If `slot == len`: go to slot 0 when `loop_en=1`. When `loop_en=0`, hold `slot` and hold `frame_cnt` at `dur`, so the playlist stops on the last slot.
    - Otherwise `slot` ← `slot+1`.
  - If `frame_cnt != dur[slot]`, `frame_cnt` ← `frame_cnt+1`.
  - Time: when `freeze=1`, `cur_time` and the divider hold. Otherwise:
    - If `div_cnt == speed`: `div_cnt` ← 0 and `cur_time` ← `cur_time+1` (mod 256, 255 wraps to 0).
    - Else `div_cnt` ← `div_cnt+1`.
- **Widths:** `frame_cnt` 6 bits, `div_cnt` 4 bits, all unsigned, no saturation beyond the rules above.

## Timing
- **Reset values** (visible the cycle after the reset edge):
  - State IDLE; all staging and active registers 0; `dirty=0`.
  - `slot=0`, `bg_select=0`, `cur_time=0`, `update=0`, `cfg_ready=1`.
- **cfg_ready** = 0 only in APPLY, otherwise 1. It is combinational from state.
- **Write acceptance:** a write accepted at edge N is in staging from cycle N+1. It is not in active before the next commit.
- **Output latency:** `frame_start` sampled at edge N changes `slot`, `bg_select`, `cur_time` and `update` from cycle N+1. `update` is high only in the APPLY cycle.
- **Mid-operation reset:** state, counters, staging, active and `dirty` all return to reset values. Any pending commit is discarded.
- **enable during frame_start:** `enable` deasserted in the same cycle as `frame_start` (no dirty) means no advance.

## Test plan
- **Reset state:** reset, then `enable=1`, 3 frame_starts with no config → `bg_select=0`, `slot=0`, `cur_time` = 1, 2, 3 after each frame.
- **Looping playlist:**
  - Write addr0=0x06 (bg 2, dur 1), addr1=0x01 (bg 1, dur 0), addr4=0x90 (loop, len 1, speed 0).
  - One frame_start → `update` pulse, `cfg_ready=0` for 1 cycle, `slot=0`, `bg_select=2`.
  - Following frames → `bg_select` 2, 2, 1, 2, 2, 1…
- **No loop:** same config but addr4=0x10 → after reaching slot 1, `bg_select` stays 1 indefinitely.
- **Speed and wrap:** speed=3, `cur_time` preloaded near 255 via frames → increments every 4th frame_start and wraps 255→0. With `freeze=1`, `cur_time` is constant.
- **Write in commit cycle:** write addr0 in the same cycle as the committing frame_start → that write is absent from active, `dirty` stays 1, and it commits on the next frame_start.
- **Disable and reset mid-play:** `enable=0` mid-playlist → `slot` and `cur_time` hold across frames. Re-enable resumes. `rst_n=0` mid-play → all outputs at reset values the next cycle.
